// File: rtl/ps2_dir_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_dir_decoder_if
// Brief    : Scan-code input strobe and event-FIFO pop handshake of the decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_dir_decoder_if #(
    parameter int IW = 2
);
    logic [7:0]  received_data;
    logic        received_data_en;
    logic [IW:0] evt_data;
    logic        evt_valid;
    logic        evt_ready;

    modport master (
        output received_data,
        output received_data_en,
        output evt_ready,
        input  evt_data,
        input  evt_valid
    );

    modport slave (
        input  received_data,
        input  received_data_en,
        input  evt_ready,
        output evt_data,
        output evt_valid
    );
endinterface
`default_nettype wire

// File: rtl/ps2_dir_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_dir_decoder
// Brief    : PS/2 scan-code parser tracking held direction keys, with an
//            event FIFO of key press/release changes and a sticky overflow.
//            Define PS2_DIR_EXT_FILTER_EN to ignore E0-prefixed codes.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_dir_decoder #(
    parameter int                    NUM_KEYS   = 4,
    parameter logic [8*NUM_KEYS-1:0] KEY_CODES  = {8'h7A, 8'h69, 8'h72, 8'h73},
    parameter int                    FIFO_DEPTH = 8
) (
    input  wire logic          CLOCK_50,
    input  wire logic          resetn,
    ps2_dir_decoder_if.slave   bus,
    output logic [NUM_KEYS-1:0] held,
    output logic [3:0]         dir_code,
    input  wire logic          ovf_clr,
    output logic               overflow
);

    localparam int c_iw = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int c_ew = c_iw + 1;
    localparam int c_pw = $clog2(FIFO_DEPTH);
    localparam logic [c_pw:0] c_depth    = (c_pw + 1)'(FIFO_DEPTH);
    localparam logic [7:0]    c_code_ext = 8'hE0;
    localparam logic [7:0]    c_code_brk = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t              r_state;
    logic [NUM_KEYS-1:0] r_held;
    logic [3:0]          r_dir;
    logic                r_ovf;

    logic [c_ew-1:0]     r_mem [FIFO_DEPTH];
    logic [c_pw-1:0]     r_wr_ptr;
    logic [c_pw-1:0]     r_rd_ptr;
    logic [c_pw:0]       r_count;

    logic                w_is_code;
    logic                w_brk;
    logic                w_match;
    logic [NUM_KEYS-1:0] w_hit;
    logic [c_iw-1:0]     w_idx;
    logic [NUM_KEYS-1:0] w_held_next;
    logic [3:0]          w_dir;
    logic                w_push;
    logic                w_valid;
    logic                w_full;
    logic                w_pop;
    logic                w_wr;
    logic                w_drop;

    // Descending scan so the lowest matching table index is the one kept.
    always_comb begin
        w_is_code = bus.received_data_en &&
                    (bus.received_data != c_code_ext) &&
                    (bus.received_data != c_code_brk);
        w_brk     = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
        w_match   = 1'b0;
        w_hit     = '0;
        w_idx     = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (KEY_CODES[8*i +: 8] == bus.received_data) begin
                w_match  = 1'b1;
                w_hit    = '0;
                w_hit[i] = 1'b1;
                w_idx    = c_iw'(i);
            end
        end
`ifdef PS2_DIR_EXT_FILTER_EN
        if ((r_state == ST_EXT) || (r_state == ST_EXT_BRK)) begin
            w_match = 1'b0;
            w_hit   = '0;
        end
`endif
        w_held_next = r_held;
        if (w_is_code && w_match) begin
            w_held_next = w_brk ? (r_held & ~w_hit) : (r_held | w_hit);
        end
        // Only a real transition is an event; repeats and stray breaks are not.
        w_push = (w_held_next != r_held);
    end

    always_comb begin
        w_dir = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (w_held_next[i]) begin
                w_dir = 4'(i + 1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_held  <= '0;
            r_dir   <= '0;
        end else begin
            r_held <= w_held_next;
            r_dir  <= w_dir;
            if (bus.received_data_en) begin
                if (bus.received_data == c_code_ext) begin
                    r_state <= ST_EXT;
                end else if (bus.received_data == c_code_brk) begin
                    case (r_state)
                        ST_IDLE: r_state <= ST_BRK;
                        ST_EXT:  r_state <= ST_EXT_BRK;
                        default: r_state <= r_state;
                    endcase
                end else begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    // When full, a same-cycle pop frees the head slot, which is also the write slot.
    always_comb begin
        w_valid = (r_count != '0);
        w_full  = (r_count == c_depth);
        w_pop   = w_valid && bus.evt_ready;
        w_wr    = w_push && (!w_full || w_pop);
        w_drop  = w_push && w_full && !w_pop;
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {w_brk, w_idx};
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_pw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_pw'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (c_pw + 1)'(1);
                2'b01:   r_count <= r_count - (c_pw + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.evt_data  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.evt_valid = w_valid;
    assign held          = r_held;
    assign dir_code      = r_dir;
    assign overflow      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ps2_dir_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_dir_decoder
// Brief    : Directed vector table plus hand sequences for overflow and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_dir_decoder;

`ifdef PS2_DIR_EXT_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic       ovf_clr  = 1'b0;
    logic [3:0] held;
    logic [3:0] dir_code;
    logic       overflow;

    ps2_dir_decoder_if #(.IW(2)) bus ();

    ps2_dir_decoder dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .bus      (bus),
        .held     (held),
        .dir_code (dir_code),
        .ovf_clr  (ovf_clr),
        .overflow (overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [7:0] d;
        logic       en;
        logic       rdy;
        logic [3:0] held;
        logic [3:0] dir;
        logic       valid;
        logic [2:0] data;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] h, input logic [3:0] dr,
                           input logic v, input logic [2:0] e, input logic ovf);
        chk({tag, ".held"}, 32'(held), 32'(h));
        chk({tag, ".dir"}, 32'(dir_code), 32'(dr));
        chk({tag, ".valid"}, 32'(bus.evt_valid), 32'(v));
        chk({tag, ".data"}, 32'(bus.evt_data), 32'(e));
        chk({tag, ".ovf"}, 32'(overflow), 32'(ovf));
    endtask

    task automatic drive(input logic [7:0] d, input logic en, input logic rdy, input logic clr);
        bus.received_data    = d;
        bus.received_data_en = en;
        bus.evt_ready        = rdy;
        ovf_clr              = clr;
        @(posedge CLOCK_50);
        #1;
        bus.received_data_en = 1'b0;
        bus.evt_ready        = 1'b0;
        ovf_clr              = 1'b0;
    endtask

    task automatic key(input logic [7:0] d, input logic [3:0] h, input logic [3:0] dr,
                       input logic v, input logic [2:0] e);
        vec_t t;
        t.d = d; t.en = 1'b1; t.rdy = 1'b0; t.held = h; t.dir = dr; t.valid = v; t.data = e;
        vecs.push_back(t);
    endtask

    task automatic pop(input logic [3:0] h, input logic [3:0] dr, input logic v, input logic [2:0] e);
        vec_t t;
        t.d = 8'h00; t.en = 1'b0; t.rdy = 1'b1; t.held = h; t.dir = dr; t.valid = v; t.data = e;
        vecs.push_back(t);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] exp_e;

        bus.received_data    = 8'h00;
        bus.received_data_en = 1'b0;
        bus.evt_ready        = 1'b0;

        key(8'h73, 4'h1, 4'd1, 1'b1, 3'b000);
        pop(4'h1, 4'd1, 1'b0, 3'b000);
        key(8'hF0, 4'h1, 4'd1, 1'b0, 3'b000);
        key(8'h73, 4'h0, 4'd0, 1'b1, 3'b100);
        pop(4'h0, 4'd0, 1'b0, 3'b000);
        key(8'h7A, 4'h8, 4'd4, 1'b1, 3'b011);
        key(8'h7A, 4'h8, 4'd4, 1'b1, 3'b011);
        key(8'h7A, 4'h8, 4'd4, 1'b1, 3'b011);
        pop(4'h8, 4'd4, 1'b0, 3'b000);
        key(8'hF0, 4'h8, 4'd4, 1'b0, 3'b000);
        key(8'h7A, 4'h0, 4'd0, 1'b1, 3'b111);
        pop(4'h0, 4'd0, 1'b0, 3'b000);
        key(8'h72, 4'h2, 4'd2, 1'b1, 3'b001);
        key(8'h69, 4'h6, 4'd2, 1'b1, 3'b001);
        key(8'hF0, 4'h6, 4'd2, 1'b1, 3'b001);
        key(8'h72, 4'h4, 4'd3, 1'b1, 3'b001);
        pop(4'h4, 4'd3, 1'b1, 3'b010);
        pop(4'h4, 4'd3, 1'b1, 3'b101);
        pop(4'h4, 4'd3, 1'b0, 3'b000);
        pop(4'h4, 4'd3, 1'b0, 3'b000);
        key(8'hF0, 4'h4, 4'd3, 1'b0, 3'b000);
        key(8'h69, 4'h0, 4'd0, 1'b1, 3'b110);
        pop(4'h0, 4'd0, 1'b0, 3'b000);
        key(8'h1C, 4'h0, 4'd0, 1'b0, 3'b000);
        key(8'hF0, 4'h0, 4'd0, 1'b0, 3'b000);
        key(8'h73, 4'h0, 4'd0, 1'b0, 3'b000);
        key(8'hE0, 4'h0, 4'd0, 1'b0, 3'b000);
        key(8'h73, FILT ? 4'h0 : 4'h1, FILT ? 4'd0 : 4'd1, !FILT, 3'b000);
        pop(FILT ? 4'h0 : 4'h1, FILT ? 4'd0 : 4'd1, 1'b0, 3'b000);
        key(8'hE0, FILT ? 4'h0 : 4'h1, FILT ? 4'd0 : 4'd1, 1'b0, 3'b000);
        key(8'hF0, FILT ? 4'h0 : 4'h1, FILT ? 4'd0 : 4'd1, 1'b0, 3'b000);
        key(8'h73, 4'h0, 4'd0, !FILT, FILT ? 3'b000 : 3'b100);
        pop(4'h0, 4'd0, 1'b0, 3'b000);
        key(8'h72, 4'h2, 4'd2, 1'b1, 3'b001);
        pop(4'h2, 4'd2, 1'b0, 3'b000);
        key(8'hF0, 4'h2, 4'd2, 1'b0, 3'b000);
        key(8'hF0, 4'h2, 4'd2, 1'b0, 3'b000);
        key(8'h72, 4'h0, 4'd0, 1'b1, 3'b101);
        pop(4'h0, 4'd0, 1'b0, 3'b000);
        key(8'hF0, 4'h0, 4'd0, 1'b0, 3'b000);
        key(8'hE0, 4'h0, 4'd0, 1'b0, 3'b000);
        key(8'h73, FILT ? 4'h0 : 4'h1, FILT ? 4'd0 : 4'd1, !FILT, 3'b000);
        pop(FILT ? 4'h0 : 4'h1, FILT ? 4'd0 : 4'd1, 1'b0, 3'b000);
        key(8'hF0, FILT ? 4'h0 : 4'h1, FILT ? 4'd0 : 4'd1, 1'b0, 3'b000);
        key(8'h73, 4'h0, 4'd0, !FILT, FILT ? 3'b000 : 3'b100);
        pop(4'h0, 4'd0, 1'b0, 3'b000);

        repeat (3) @(posedge CLOCK_50);
        #1;
        chk_all("reset", 4'h0, 4'd0, 1'b0, 3'b000, 1'b0);
        resetn = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].d, vecs[k].en, vecs[k].rdy, 1'b0);
            chk_all($sformatf("v%0d", k), vecs[k].held, vecs[k].dir,
                    vecs[k].valid, vecs[k].data, 1'b0);
        end

        // Nine changes into an eight-deep FIFO: the ninth is dropped.
        for (int k = 0; k < 9; k++) begin
            if (k % 2 == 1) drive(8'hF0, 1'b1, 1'b0, 1'b0);
            drive(8'h73, 1'b1, 1'b0, 1'b0);
        end
        chk_all("ovf_set", 4'h1, 4'd1, 1'b1, 3'b000, 1'b1);
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'd0);
        drive(8'hF0, 1'b0 | 1'b1, 1'b0, 1'b0);
        drive(8'h73, 1'b1, 1'b0, 1'b1);
        chk_all("ovf_clr_drop", 4'h0, 4'd0, 1'b1, 3'b000, 1'b1);
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr2", 32'(overflow), 32'd0);
        drive(8'h73, 1'b1, 1'b1, 1'b0);
        chk_all("full_pushpop", 4'h1, 4'd1, 1'b1, 3'b100, 1'b0);
        for (int k = 0; k < 8; k++) begin
            exp_e = (k % 2 == 0) ? 3'b100 : 3'b000;
            chk($sformatf("drain%0d.valid", k), 32'(bus.evt_valid), 32'd1);
            chk($sformatf("drain%0d.data", k), 32'(bus.evt_data), 32'(exp_e));
            drive(8'h00, 1'b0, 1'b1, 1'b0);
        end
        chk("drain_empty", 32'(bus.evt_valid), 32'd0);

        // Reset between F0 and the code must leave no pending break.
        drive(8'h72, 1'b1, 1'b0, 1'b0);
        drive(8'hF0, 1'b1, 1'b0, 1'b0);
        chk_all("pre_rst", 4'h3, 4'd1, 1'b1, 3'b001, 1'b0);
        resetn = 1'b0;
        #1;
        chk_all("async_rst", 4'h0, 4'd0, 1'b0, 3'b000, 1'b0);
        @(posedge CLOCK_50);
        #1;
        resetn = 1'b1;
        drive(8'h73, 1'b1, 1'b0, 1'b0);
        chk_all("post_rst_make", 4'h1, 4'd1, 1'b1, 3'b000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_dir_decoder.md
PS2_DIR_DECODER -- requirements
Module: ps2_dir_decoder

Interface
REQ-001 Parameter NUM_KEYS, default 4: number of tracked keys, range 1..15.
REQ-002 Parameter KEY_CODES, default {8'h7A,8'h69,8'h72,8'h73}: packed 8*NUM_KEYS scan-code table; key i occupies bits [8i+7:8i].
REQ-003 Parameter FIFO_DEPTH, default 8: event FIFO entries, a power of 2 and at least 2.
REQ-004 CLOCK_50  input  1  system clock; all state updates occur on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 received_data  input  8  scan-code byte from the PS/2 controller.
REQ-007 received_data_en  input  1  single-cycle strobe; received_data is valid while it is high.
REQ-008 held  output  NUM_KEYS  bit i is high while key i is pressed.
REQ-009 dir_code  output  4  1 + index of the lowest-index held key; 0 when no key is held.
REQ-010 evt_data  output  1+IW  FIFO head as {brk, index}, where IW = clog2(NUM_KEYS), minimum 1, and brk=1 marks a release.
REQ-011 evt_valid  output  1  FIFO is non-empty.
REQ-012 evt_ready  input  1  consumer pop; a pop occurs when evt_valid and evt_ready are both high.
REQ-013 ovf_clr  input  1  synchronous clear of overflow.
REQ-014 overflow  output  1  sticky flag: at least one event was dropped.

Function
REQ-015 The parser SHALL have four states: IDLE, BRK, EXT, EXT_BRK; only cycles with received_data_en=1 advance it.
REQ-016 On byte E0: the parser SHALL go to EXT from any state.
REQ-017 On byte F0: IDLE goes to BRK, EXT goes to EXT_BRK, and BRK or EXT_BRK is unchanged.
REQ-018 On any other byte: the parser SHALL decode it as a make (IDLE/EXT) or break (BRK/EXT_BRK) and return to IDLE.
REQ-019 A code matching KEY_CODES entry i SHALL set held[i] on a make and clear it on a break; if multiple entries match, the lowest index wins.
REQ-020 A code matching no entry SHALL cause no state or FIFO change other than the return to IDLE.
REQ-021 A decoded byte at edge N SHALL appear on held and dir_code after edge N, i.e. with 1-cycle latency.
REQ-022 An event SHALL be pushed only when held[i] actually changes; typematic repeat makes and breaks of unheld keys push nothing.
REQ-023 A pushed event SHALL be visible on evt_data and evt_valid after the same edge that updates held, when the FIFO was empty.
REQ-024 evt_data SHALL present the oldest entry; the FIFO is strictly FIFO-ordered and pointers wrap modulo FIFO_DEPTH.
REQ-025 Push to a full FIFO without a same-cycle pop SHALL drop the new event and set overflow; existing entries are unchanged.
REQ-026 Simultaneous push and pop SHALL both take effect at any occupancy, including full; the count is then unchanged.
REQ-027 A pop on an empty FIFO SHALL be ignored.
REQ-028 ovf_clr=1 SHALL clear overflow at the next edge; if a drop occurs in the same cycle, overflow stays at 1.

Reset
REQ-029 resetn=0 SHALL asynchronously set: parser to IDLE, held=0, dir_code=0, FIFO empty (evt_valid=0), overflow=0, evt_data=0.
REQ-030 Reset mid-sequence (for example after F0) SHALL discard the prefix, so the next plain code is treated as a make.
REQ-031 On release of resetn, the first received_data_en SHALL be processed normally in that same cycle.

Configuration
REQ-032 Macro PS2_DIR_EXT_FILTER_EN defined: codes decoded in EXT or EXT_BRK never match the table (arrow keys are distinct from keypad keys) and push no event.
REQ-033 Macro PS2_DIR_EXT_FILTER_EN undefined: E0 only tracks state, and codes decoded in EXT or EXT_BRK match the table exactly as in IDLE or BRK.

Verification
REQ-034 Send 73 -> held=0001, dir_code=1, evt_data={0,0}; then send F0,73 -> held=0000, dir_code=0, evt_data={1,0}.
REQ-035 Send 7A, 7A, 7A with no pops -> exactly one event {0,3} in the FIFO, held=1000, dir_code=4.
REQ-036 Send 72 then 69 -> held=0110, dir_code=2; then send F0,72 -> dir_code=3; FIFO order is {0,1},{0,2},{1,1}.
REQ-037 With evt_ready=0, cause 9 state changes at depth 8 -> 8 entries held, overflow=1, ninth event lost; then pulse ovf_clr -> overflow=0.
REQ-038 Send E0,73: with the macro -> held unchanged and no event; without the macro -> held=0001 and event {0,0}.
REQ-039 Send F0, assert resetn=0 for 1 cycle, then send 73 -> held=0001 (a make), no stale break.
